spi_master_cmd_data: RTL and testbench

//  SPI mode-0 master that drives the FPGA's two-chip-select SPI slave port (cmd CS + data CS) from the

---
 rtl/spi_master_cmd_data_if.sv | 22 ++
 rtl/spi_master_cmd_data.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_master_cmd_data.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_cmd_data_if.sv
// Control-side bundle for spi_master_cmd_data: request handshake, command/data words and completion.
// skip_cmd exists only when SPI_MASTER_SKIP_CMD_EN is defined.
interface spi_master_cmd_data_if #(
    parameter int width_cmd  = 8,
    parameter int width_data = 16
);
    logic                  start;
    logic [width_cmd-1:0]  cmd_in;
    logic [width_data-1:0] data_in;
    logic [width_data-1:0] data_out;
    logic                  busy;
    logic                  done;
`ifdef SPI_MASTER_SKIP_CMD_EN
    logic                  skip_cmd;

    modport master (output start, cmd_in, data_in, skip_cmd, input data_out, busy, done);
    modport slave  (input start, cmd_in, data_in, skip_cmd, output data_out, busy, done);
`else
    modport master (output start, cmd_in, data_in, input data_out, busy, done);
    modport slave  (input start, cmd_in, data_in, output data_out, busy, done);
`endif
endinterface

// File: rtl/spi_master_cmd_data.sv
// SPI mode-0 master for a two-chip-select slave: command word on spi_cs_cmd, then full-duplex data on spi_cs_data.
// Optional SPI_MASTER_SKIP_CMD_EN adds ctrl.skip_cmd to run a data-only transaction.
module spi_master_cmd_data #(
    parameter int width_cmd  = 8,
    parameter int width_data = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_master_cmd_data_if.slave ctrl,
    output logic                 spi_scl,
    output logic                 spi_sdo,
    input  logic                 spi_sdi,
    output logic                 spi_cs_cmd,
    output logic                 spi_cs_data
);
    localparam int MAX_W = (width_cmd > width_data) ? width_cmd : width_data;
    localparam int CNT_W = (MAX_W > 2) ? $clog2(MAX_W) : 1;
    localparam int TMR_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(width_cmd - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(width_data - 1);
    localparam logic [TMR_W-1:0] HALF_END  = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_END   = TMR_W'(2 * CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, CMD_SETUP, CMD_SHIFT, CMD_HOLD, GAP,
        DATA_SETUP, DATA_SHIFT, DATA_HOLD, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]      bit_q, bit_d;
    logic [width_cmd-1:0]  cmd_sr_q, cmd_sr_d;
    logic [width_data-1:0] dat_sr_q, dat_sr_d;
    logic [width_data-1:0] rx_q, rx_d;
    logic [width_data-1:0] dout_q, dout_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  scl_q, scl_d;
    logic                  sdo_q, sdo_d;
    logic                  cs_cmd_q, cs_cmd_d;
    logic                  cs_dat_q, cs_dat_d;

    logic skip;
    logic half_end;
    logic gap_end;
    logic last_bit;

`ifdef SPI_MASTER_SKIP_CMD_EN
    assign skip = ctrl.skip_cmd;
`else
    assign skip = 1'b0;
`endif

    assign half_end = (timer_q == HALF_END);
    assign gap_end  = (timer_q == GAP_END);
    assign last_bit = (bit_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            cmd_sr_q <= '0;
            dat_sr_q <= '0;
            rx_q     <= '0;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            scl_q    <= 1'b0;
            sdo_q    <= 1'b0;
            cs_cmd_q <= 1'b1;
            cs_dat_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            cmd_sr_q <= cmd_sr_d;
            dat_sr_q <= dat_sr_d;
            rx_q     <= rx_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            scl_q    <= scl_d;
            sdo_q    <= sdo_d;
            cs_cmd_q <= cs_cmd_d;
            cs_dat_q <= cs_dat_d;
        end
    end

    // The timer restarts at every state change and at every SCL edge inside a shift state.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (ctrl.start) state_d = skip ? DATA_SETUP : CMD_SETUP;
            end
            CMD_SETUP: if (half_end) begin
                state_d = CMD_SHIFT;
                timer_d = '0;
            end
            CMD_SHIFT: if (half_end) begin
                timer_d = '0;
                if (scl_q && last_bit) state_d = CMD_HOLD;
            end
            CMD_HOLD: if (half_end) begin
                state_d = GAP;
                timer_d = '0;
            end
            GAP: if (gap_end) begin
                state_d = DATA_SETUP;
                timer_d = '0;
            end
            DATA_SETUP: if (half_end) begin
                state_d = DATA_SHIFT;
                timer_d = '0;
            end
            DATA_SHIFT: if (half_end) begin
                timer_d = '0;
                if (scl_q && last_bit) state_d = DATA_HOLD;
            end
            DATA_HOLD: if (half_end) begin
                state_d = DONE;
                timer_d = '0;
            end
            DONE: begin
                state_d = IDLE;
                timer_d = '0;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        bit_d    = bit_q;
        cmd_sr_d = cmd_sr_q;
        dat_sr_d = dat_sr_q;
        rx_d     = rx_q;
        dout_d   = dout_q;
        busy_d   = busy_q;
        done_d   = done_q;
        scl_d    = scl_q;
        sdo_d    = sdo_q;
        cs_cmd_d = cs_cmd_q;
        cs_dat_d = cs_dat_q;
        case (state_q)
            IDLE: if (ctrl.start) begin
                busy_d   = 1'b1;
                cmd_sr_d = ctrl.cmd_in;
                dat_sr_d = ctrl.data_in;
                if (skip) begin
                    cs_dat_d = 1'b0;
                    sdo_d    = ctrl.data_in[width_data-1];
                    bit_d    = DATA_LAST;
                end else begin
                    cs_cmd_d = 1'b0;
                    sdo_d    = ctrl.cmd_in[width_cmd-1];
                    bit_d    = CMD_LAST;
                end
            end
            CMD_SHIFT: if (half_end) begin
                if (!scl_q) begin
                    scl_d = 1'b1;
                end else begin
                    scl_d = 1'b0;
                    if (last_bit) begin
                        sdo_d = 1'b0;
                    end else begin
                        bit_d    = bit_q - 1'b1;
                        cmd_sr_d = {cmd_sr_q[width_cmd-2:0], 1'b0};
                        sdo_d    = cmd_sr_q[width_cmd-2];
                    end
                end
            end
            CMD_HOLD: if (half_end) cs_cmd_d = 1'b1;
            GAP: if (gap_end) begin
                cs_dat_d = 1'b0;
                sdo_d    = dat_sr_q[width_data-1];
                bit_d    = DATA_LAST;
            end
            DATA_SHIFT: if (half_end) begin
                if (!scl_q) begin
                    scl_d = 1'b1;
                    rx_d  = {rx_q[width_data-2:0], spi_sdi};
                end else begin
                    scl_d = 1'b0;
                    if (last_bit) begin
                        sdo_d = 1'b0;
                    end else begin
                        bit_d    = bit_q - 1'b1;
                        dat_sr_d = {dat_sr_q[width_data-2:0], 1'b0};
                        sdo_d    = dat_sr_q[width_data-2];
                    end
                end
            end
            DATA_HOLD: if (half_end) begin
                cs_dat_d = 1'b1;
                dout_d   = rx_q;
                done_d   = 1'b1;
            end
            DONE: begin
                done_d = 1'b0;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign spi_scl       = scl_q;
    assign spi_sdo       = sdo_q;
    assign spi_cs_cmd    = cs_cmd_q;
    assign spi_cs_data   = cs_dat_q;
    assign ctrl.busy     = busy_q;
    assign ctrl.done     = done_q;
    assign ctrl.data_out = dout_q;
endmodule

// File: tb/tb_spi_master_cmd_data.sv
// Bench for spi_master_cmd_data: two DUTs (default and CLK_DIV=8/32-bit data), each paired with a
// behavioural two-CS SPI slave that records what it sees on the wire and returns a chosen word.
module tb_spi_master_cmd_data;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    spi_master_cmd_data_if #(.width_cmd(8), .width_data(16)) if_a ();
    spi_master_cmd_data_if #(.width_cmd(8), .width_data(32)) if_b ();

    logic a_scl, a_sdo, a_csc, a_csd;
    logic b_scl, b_sdo, b_csc, b_csd;
    logic a_sdi = 1'b0;
    logic b_sdi = 1'b0;

    spi_master_cmd_data #(.width_cmd(8), .width_data(16), .CLK_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .ctrl(if_a), .spi_scl(a_scl), .spi_sdo(a_sdo),
        .spi_sdi(a_sdi), .spi_cs_cmd(a_csc), .spi_cs_data(a_csd));

    spi_master_cmd_data #(.width_cmd(8), .width_data(32), .CLK_DIV(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .ctrl(if_b), .spi_scl(b_scl), .spi_sdo(b_sdo),
        .spi_sdi(b_sdi), .spi_cs_cmd(b_csc), .spi_cs_data(b_csd));

    // Slave models: sample the wire on the falling clk edge, capture sdo on SCL rise,
    // present Din MSB-first (first bit at data-CS fall, next bits on SCL fall).
    logic [63:0] a_din = '0, a_cmd_cap = '0, a_dat_cap = '0;
    int a_cmd_n = 0, a_dat_n = 0, a_beg_n = 0, a_end_n = 0, a_both = 0, a_orph = 0;
    int a_csc_lo = 0, a_csd_lo = 0, a_idx = 0;
    logic a_scl_p = 1'b0, a_csd_p = 1'b1;

    always @(negedge clk) begin
        a_scl_p <= a_scl;
        a_csd_p <= a_csd;
        if (!a_csc) a_csc_lo <= a_csc_lo + 1;
        if (!a_csd) a_csd_lo <= a_csd_lo + 1;
        if (!a_csc && !a_csd) a_both <= a_both + 1;
        if ((a_scl != a_scl_p) && a_csc && a_csd) a_orph <= a_orph + 1;
        if (a_csd_p && !a_csd) begin
            a_beg_n <= a_beg_n + 1;
            a_sdi   <= a_din[15];
            a_idx   <= 14;
        end else if (a_scl_p && !a_scl && !a_csd && a_idx >= 0) begin
            a_sdi <= a_din[a_idx[5:0]];
            a_idx <= a_idx - 1;
        end
        if (!a_csd_p && a_csd) a_end_n <= a_end_n + 1;
        if (!a_scl_p && a_scl && !a_csc) begin
            a_cmd_cap <= {a_cmd_cap[62:0], a_sdo};
            a_cmd_n   <= a_cmd_n + 1;
        end
        if (!a_scl_p && a_scl && !a_csd) begin
            a_dat_cap <= {a_dat_cap[62:0], a_sdo};
            a_dat_n   <= a_dat_n + 1;
        end
    end

    logic [63:0] b_din = '0, b_cmd_cap = '0, b_dat_cap = '0;
    int b_cmd_n = 0, b_dat_n = 0, b_beg_n = 0, b_end_n = 0, b_both = 0, b_orph = 0;
    int b_csc_lo = 0, b_csd_lo = 0, b_idx = 0;
    logic b_scl_p = 1'b0, b_csd_p = 1'b1;

    always @(negedge clk) begin
        b_scl_p <= b_scl;
        b_csd_p <= b_csd;
        if (!b_csc) b_csc_lo <= b_csc_lo + 1;
        if (!b_csd) b_csd_lo <= b_csd_lo + 1;
        if (!b_csc && !b_csd) b_both <= b_both + 1;
        if ((b_scl != b_scl_p) && b_csc && b_csd) b_orph <= b_orph + 1;
        if (b_csd_p && !b_csd) begin
            b_beg_n <= b_beg_n + 1;
            b_sdi   <= b_din[31];
            b_idx   <= 30;
        end else if (b_scl_p && !b_scl && !b_csd && b_idx >= 0) begin
            b_sdi <= b_din[b_idx[5:0]];
            b_idx <= b_idx - 1;
        end
        if (!b_csd_p && b_csd) b_end_n <= b_end_n + 1;
        if (!b_scl_p && b_scl && !b_csc) begin
            b_cmd_cap <= {b_cmd_cap[62:0], b_sdo};
            b_cmd_n   <= b_cmd_n + 1;
        end
        if (!b_scl_p && b_scl && !b_csd) begin
            b_dat_cap <= {b_dat_cap[62:0], b_sdo};
            b_dat_n   <= b_dat_n + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt(input bit sel, input int k);
        case (k)
            0:       return sel ? b_cmd_n  : a_cmd_n;
            1:       return sel ? b_dat_n  : a_dat_n;
            2:       return sel ? b_beg_n  : a_beg_n;
            3:       return sel ? b_end_n  : a_end_n;
            4:       return sel ? b_both   : a_both;
            5:       return sel ? b_orph   : a_orph;
            6:       return sel ? b_csc_lo : a_csc_lo;
            default: return sel ? b_csd_lo : a_csd_lo;
        endcase
    endfunction

    function automatic logic [63:0] dout(input bit sel);
        return sel ? 64'(if_b.data_out) : 64'(if_a.data_out);
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) if_b.start = v;
        else if_a.start = v;
    endtask

    // Caller must be at the falling edge of an IDLE cycle; returns at the falling edge of the cycle after done.
    task automatic run_txn(input bit sel, input logic [7:0] cmd, input logic [31:0] dat,
                           input logic [31:0] din, input bit skip, input bit spam, input string tag);
        int wd, d, lat, n;
        int c0 [8];
        logic [63:0] mask, prev;
        bit busy_ok, stable_ok, seen;
        wd   = sel ? 32 : 16;
        d    = sel ? 8 : 4;
        mask = (64'd1 << wd) - 64'd1;
        lat  = skip ? 2 + (2 + 2 * wd) * d : 2 + (2 + 2 * 8) * d + 2 * d + (2 + 2 * wd) * d;
        for (int k = 0; k < 8; k++) c0[k] = cnt(sel, k);
        if (sel) begin
            b_din = 64'(din) & mask;
            if_b.cmd_in  = cmd;
            if_b.data_in = dat;
        end else begin
            a_din = 64'(din) & mask;
            if_a.cmd_in  = cmd;
            if_a.data_in = dat[15:0];
        end
`ifdef SPI_MASTER_SKIP_CMD_EN
        if (sel) if_b.skip_cmd = skip;
        else if_a.skip_cmd = skip;
`endif
        prev = dout(sel);
        set_start(sel, 1'b1);
        n = 1; busy_ok = 1'b1; stable_ok = 1'b1; seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!spam) set_start(sel, 1'b0);
            n++;
            if (!(sel ? if_b.busy : if_a.busy)) busy_ok = 1'b0;
            if (sel ? if_b.done : if_a.done) begin
                seen = 1'b1;
                break;
            end
            if (dout(sel) !== prev) stable_ok = 1'b0;
        end
        set_start(sel, 1'b0);
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_data_out"}, dout(sel), 64'(din) & mask);
        check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        check({tag, "_data_out_stable"}, 64'(stable_ok), 64'd1);
        @(negedge clk);
        check({tag, "_idle_done_busy"}, {62'd0, (sel ? if_b.done : if_a.done), (sel ? if_b.busy : if_a.busy)}, 64'd0);
        check({tag, "_data_out_held"}, dout(sel), 64'(din) & mask);
        check({tag, "_cmd_bits"}, 64'(cnt(sel, 0) - c0[0]), skip ? 64'd0 : 64'd8);
        if (!skip) check({tag, "_slave_cmd"}, (sel ? b_cmd_cap : a_cmd_cap) & 64'hFF, 64'(cmd));
        check({tag, "_data_bits"}, 64'(cnt(sel, 1) - c0[1]), 64'(wd));
        check({tag, "_slave_dout"}, (sel ? b_dat_cap : a_dat_cap) & mask, 64'(dat) & mask);
        check({tag, "_begin_end"}, {32'(cnt(sel, 2) - c0[2]), 32'(cnt(sel, 3) - c0[3])}, {32'd1, 32'd1});
        check({tag, "_both_cs_low"}, 64'(cnt(sel, 4) - c0[4]), 64'd0);
        check({tag, "_scl_no_cs"}, 64'(cnt(sel, 5) - c0[5]), 64'd0);
        check({tag, "_cs_cmd_low_cycles"}, 64'(cnt(sel, 6) - c0[6]), skip ? 64'd0 : 64'((2 + 16) * d));
        check({tag, "_cs_data_low_cycles"}, 64'(cnt(sel, 7) - c0[7]), 64'((2 + 2 * wd) * d));
    endtask

    initial begin
        logic [7:0]  rc;
        logic [31:0] rd, rx;
        int d0;
        if_a.start = 1'b0; if_a.cmd_in = '0; if_a.data_in = '0;
        if_b.start = 1'b0; if_b.cmd_in = '0; if_b.data_in = '0;
`ifdef SPI_MASTER_SKIP_CMD_EN
        if_a.skip_cmd = 1'b0;
        if_b.skip_cmd = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_a_pins", {58'd0, a_scl, a_sdo, a_csc, a_csd, if_a.busy, if_a.done}, 64'b001100);
        check("reset_a_data_out", dout(1'b0), 64'd0);
        check("reset_b_pins", {58'd0, b_scl, b_sdo, b_csc, b_csd, if_b.busy, if_b.done}, 64'b001100);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 8'hA5, 32'h1234, 32'hBEEF, 1'b0, 1'b0, "basic");
        run_txn(1'b0, 8'h00, 32'h8001, 32'($urandom), 1'b0, 1'b0, "b2b_first");
        run_txn(1'b0, 8'hFF, 32'h7FFE, 32'($urandom), 1'b0, 1'b0, "b2b_second");
        run_txn(1'b0, 8'h3C, 32'hC3C3, 32'h5AA5, 1'b0, 1'b1, "start_spam");

        // Abort during data bit 7 (the ninth data bit) of a transaction.
        d0 = a_dat_n;
        if_a.cmd_in = 8'h96; if_a.data_in = 16'h0F0F; a_din = 64'h1111;
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (a_dat_n - d0 >= 9) break;
            @(negedge clk);
        end
        check("abort_in_data_phase", {62'd0, a_csd, if_a.busy}, 64'b01);
        rst_n = 1'b0;
        #1;
        check("abort_pins", {58'd0, a_scl, a_sdo, a_csc, a_csd, if_a.busy, if_a.done}, 64'b001100);
        check("abort_data_out", dout(1'b0), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 8'h5A, 32'hA55A, 32'h0F0F, 1'b0, 1'b0, "after_abort");

        for (int i = 0; i < 4; i++) begin
            rc = 8'($urandom); rd = $urandom; rx = $urandom;
            run_txn(1'b0, rc, rd, rx, 1'b0, 1'b0, $sformatf("rand_a%0d", i));
        end

        run_txn(1'b1, 8'hC7, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0, "wide");
        rc = 8'($urandom); rd = $urandom; rx = $urandom;
        run_txn(1'b1, rc, rd, rx, 1'b0, 1'b0, "rand_b");

`ifdef SPI_MASTER_SKIP_CMD_EN
        run_txn(1'b0, 8'hA5, 32'h1234, 32'hBEEF, 1'b1, 1'b0, "skip_cmd");
        run_txn(1'b0, 8'h81, 32'h4321, 32'h9876, 1'b0, 1'b0, "after_skip");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
